// File: rtl/stall_flush_unit.sv
// stall_flush_unit
//
// Pipeline stall/flush controller for the 5-stage RISC-V core. Forwarding
// resolves most data hazards by bypassing. This block handles the hazards
// that bypassing cannot resolve:
//   - load-use hazards between Decode and Execute (one bubble),
//   - control flushes on taken branches and jumps resolved in Execute,
//   - a multi-cycle MUL/DIV that occupies Execute for MD_CYCLES cycles.
// It also keeps a saturating count of front-end stall cycles for the
// performance counters.
//
// Parameters:
//   MD_CYCLES    total cycles a MUL/DIV occupies Execute (2..16)
//   CNT_W        width of the stall-cycle counter
//
// Ports:
//   clk          core clock, rising-edge
//   rst          synchronous active-high reset
//   RS1_D/RS2_D  source registers of the Decode instruction
//   RD_E         destination register of the Execute instruction
//   RegWriteE    Execute instruction writes the register file
//   ResultSrcE0  Execute instruction is a load
//   PCSrcE       taken branch/jump resolved in Execute
//   MulDivStartE Execute instruction is a MUL/DIV (held high while stalled)
//   StallF/D/E   hold PC, IF/ID, ID/EX registers
//   FlushD/E/M   clear IF/ID, ID/EX, EX/MEM registers
//   MdBusy       MUL/DIV sequencer is in BUSY
//   MdDoneE      MUL/DIV result is valid in Execute this cycle
//   StallCount   saturating count of cycles with StallF set

module stall_flush_unit #(
    parameter int MD_CYCLES = 4,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       RS1_D,
    input  logic [4:0]       RS2_D,
    input  logic [4:0]       RD_E,
    input  logic             RegWriteE,
    input  logic             ResultSrcE0,
    input  logic             PCSrcE,
    input  logic             MulDivStartE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             MdBusy,
    output logic             MdDoneE,
    output logic [CNT_W-1:0] StallCount
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdState_t;

    localparam logic [3:0] CNT_LOAD = 4'(MD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    mdState_t         state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stallCount_q;

    logic mdHold;
    logic mdDone;
    logic lwStall;
    logic branchFlush;

    // MUL/DIV sequencer next state. The start request is only honoured in
    // IDLE; while BUSY it is expected to stay high (the instruction is held
    // in Execute) and is deliberately ignored.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (MulDivStartE) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Hazard detection. The hold covers the issue cycle and every BUSY cycle
    // except the last one, in which the result is ready and Execute may
    // advance. Everything is gated by reset so that no stall or flush
    // escapes while the core is being reset.
    always_comb begin
        mdHold      = 1'b0;
        mdDone      = 1'b0;
        lwStall     = 1'b0;
        branchFlush = 1'b0;
        if (!rst) begin
            mdHold = ((state_q == IDLE) && MulDivStartE) ||
                     ((state_q == BUSY) && (cnt_q != 4'd1));
            mdDone = (state_q == BUSY) && (cnt_q == 4'd1);
            // x0 is hard-wired to zero, so a load to x0 is never a hazard.
            // The MUL/DIV hold takes priority: Execute is frozen anyway.
            lwStall = ResultSrcE0 && RegWriteE && (RD_E != 5'd0) &&
                      ((RD_E == RS1_D) || (RD_E == RS2_D)) && !mdHold;
            // A branch cannot be the held MUL/DIV, so PCSrcE during a hold
            // is spurious and must not flush anything.
            branchFlush = PCSrcE && !mdHold;
        end
    end

    assign StallF     = mdHold || lwStall;
    assign StallD     = mdHold || lwStall;
    assign StallE     = mdHold;
    assign FlushM     = mdHold;
    assign FlushD     = branchFlush;
    assign FlushE     = lwStall || branchFlush;
    assign MdBusy     = !rst && (state_q == BUSY);
    assign MdDoneE    = mdDone;
    assign StallCount = stallCount_q;

    // Sequencer state and stall counter. Reset abandons any in-flight
    // MUL/DIV so its done pulse never appears.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            stallCount_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (StallF && (stallCount_q != CNT_MAX)) begin
                stallCount_q <= stallCount_q + CNT_ONE;
            end
        end
    end

endmodule
